store_lane_aligner: RTL

Registered store-path stage between the EX/MEM pipeline register and the data-memory write port. It does the reverse of the immediate sign extender: the sign extender widens a 16-bit field to 32 bits, and this block narrows a 32-bit register value to the byte or halfword named by the store. For sb, sh and sw it replicates the value into the correct byte lanes, produces byte enables, word-aligns the address and flags misaligned or illegal sizes. It has a valid/ready handshake with a 2-entry skid buffer, so memory stalls never drop or duplicate a store.

---
 rtl/store_lane_aligner.sv | 62 ++++++
 1 files changed

// File: rtl/store_lane_aligner.sv
// store_lane_aligner: narrows a store to its byte lanes, builds byte enables and buffers through a 2-entry skid
module store_lane_aligner #(
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [31:0] in_addr,
  input  logic [1:0]  in_size,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_wdata,
  output logic [3:0]  out_be,
  output logic        out_err
);
  logic [68:0] req, or_q, sr_q;
  logic        or_v, sr_v, acc, mis, err;
  logic [31:0] wd;
  logic [3:0]  be;
  // lane replication, enables and error for the incoming request, packed as {err, be, wdata, addr}
  always_comb begin
    wd  = in_size == 2'b00 ? {4{in_data[7:0]}} : in_size == 2'b01 ? {2{in_data[15:0]}} : in_data;
    be  = in_size == 2'b00 ? 4'b0001 << in_addr[1:0] :
          in_size == 2'b01 ? (in_addr[1] ? 4'b1100 : 4'b0011) :
          in_size == 2'b10 ? 4'b1111 : 4'b0000;
    mis = in_size == 2'b01 ? in_addr[0] : (in_size == 2'b10 && in_addr[1:0] != 2'b00);
    err = in_size == 2'b11 || (MISALIGN_TRAP && mis);
    req = {err, err ? 4'b0000 : be, wd, in_addr[31:2], 2'b00};
  end
  assign in_ready = !sr_v && !flush;
  assign acc = in_valid && in_ready;
  assign out_valid = or_v;
  assign {out_err, out_be, out_wdata, out_addr} = or_q;
  // output register advances from the skid first so order stays FIFO; skid only fills while the output stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_v <= 1'b0;
      sr_v <= 1'b0;
      or_q <= '0;
      sr_q <= '0;
    end else if (flush) begin
      or_v <= 1'b0;
      sr_v <= 1'b0;
    end else if (!or_v || out_ready) begin
      if (sr_v) begin
        or_q <= sr_q;
        or_v <= 1'b1;
        sr_v <= 1'b0;
      end else begin
        or_v <= acc;
        if (acc) or_q <= req;
      end
    end else if (acc) begin
      sr_q <= req;
      sr_v <= 1'b1;
    end
  end
endmodule
